// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipelined-core run controller.
package pipeline_pkg;

    localparam int          PIPE_STAGES   = 5;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CPURST,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } run_state_e;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the pipelined MIPS core: loads a program, resets and runs the core,
// stops on fetch count + drain or a retired HALT word, and reports counts and timeout.
module pipeline_run_ctrl
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter int                STAGES    = PIPE_STAGES,
    parameter int                CNT_W     = 16,
    parameter logic [CNT_W-1:0]  MAX_CYC   = CNT_W'(4096),
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst_n,
    output logic              cpu_en,
    input  logic              fetch_strobe,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_inst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int SW = ((STAGES + 2) <= 4) ? 2 : $clog2(STAGES + 2);

    localparam logic [ADDR_W:0]  IDX_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [SW-1:0]    STEP_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    DRAIN_LAST = SW'(STAGES - 2);
    localparam logic [CNT_W-1:0] TO_LIMIT   = MAX_CYC - {{(CNT_W-1){1'b0}}, 1'b1};

    run_state_e        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   fetched_q, fetched_d;
    logic [SW-1:0]     step_q, step_d;
    logic              timeout_q, timeout_d;

    logic              cnt_clr;
    logic              cyc_inc;
    logic              ret_inc;
    logic              timeout_hit;
    logic              halt_seen;

    assign timeout_hit = (cycle_count == TO_LIMIT);
    assign halt_seen   = wb_valid && (wb_inst == HALT_WORD);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        prog_len_d = prog_len_q;
        idx_d      = idx_q;
        fetched_d  = fetched_q;
        step_d     = step_q;
        timeout_d  = timeout_q;
        cnt_clr    = 1'b0;
        cyc_inc    = 1'b0;
        ret_inc    = 1'b0;
        ld_ready   = 1'b0;
        im_we      = 1'b0;
        im_addr    = '0;
        im_wdata   = '0;
        cpu_rst_n  = 1'b0;
        cpu_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE leaves the core out of reset so its state can be inspected
                cpu_rst_n = (state_q == ST_DONE);
                if (start) begin
                    mode_d     = mode;
                    prog_len_d = prog_len;
                    idx_d      = '0;
                    fetched_d  = '0;
                    step_d     = '0;
                    timeout_d  = 1'b0;
                    cnt_clr    = 1'b1;
                    state_d    = (prog_len == '0) ? ST_CPURST : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    im_we    = 1'b1;
                    im_addr  = idx_q[ADDR_W-1:0];
                    im_wdata = ld_data;
                    idx_d    = idx_q + IDX_ONE;
                    if (idx_d == prog_len_q) begin
                        state_d = ST_CPURST;
                    end
                end
            end
            ST_CPURST: begin
                if (step_q == STEP_ONE) begin
                    step_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            ST_RUN: begin
                cpu_rst_n = 1'b1;
                cpu_en    = 1'b1;
                cyc_inc   = 1'b1;
                ret_inc   = wb_valid;
                if (fetch_strobe && (fetched_q != prog_len_q)) begin
                    fetched_d = fetched_q + IDX_ONE;
                end
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (mode_q) begin
                    if (halt_seen) begin
                        state_d = ST_DONE;
                    end
                end else if (fetched_d == prog_len_q) begin
                    step_d  = '0;
                    state_d = (STAGES > 1) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                cpu_rst_n = 1'b1;
                cpu_en    = 1'b1;
                cyc_inc   = 1'b1;
                ret_inc   = wb_valid;
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (step_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            prog_len_q <= '0;
            idx_q      <= '0;
            fetched_q  <= '0;
            step_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            prog_len_q <= prog_len_d;
            idx_q      <= idx_d;
            fetched_q  <= fetched_d;
            step_q     <= step_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign timeout = timeout_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cyc_inc),
        .count (cycle_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (ret_inc),
        .count (retired_count)
    );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Randomized self-checking bench for pipeline_run_ctrl against a run-length reference model.
module tb_pipeline_run_ctrl;

    localparam int          STG  = 5;
    localparam int          MAXC = 32;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [8:0]  prog_len;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        cpu_en;
    logic        fetch_strobe;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (32),
        .STAGES    (STG),
        .CNT_W     (16),
        .MAX_CYC   (16'd32),
        .HALT_WORD (HALT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .prog_len      (prog_len),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .im_we         (im_we),
        .im_addr       (im_addr),
        .im_wdata      (im_wdata),
        .cpu_rst_n     (cpu_rst_n),
        .cpu_en        (cpu_en),
        .fetch_strobe  (fetch_strobe),
        .wb_valid      (wb_valid),
        .wb_inst       (wb_inst),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction: load, core reset, run, and final report.
    task automatic run_case(input string nm, input logic md, input int len, input int stall_pct,
                            input bit stall3, input int fetch_pct, input int wb_pct,
                            input int halt_n, input bit start_in_run, input int abort_k);
        logic [31:0] prog [$];
        bit          f [64];
        bit          v [64];
        logic [31:0] wi [64];
        int          n, guard, stalled, cnt, nv, natural, total, exp_ret;
        bit          exp_to, first;

        for (int j = 0; j < len; j++) prog.push_back($urandom);
        for (int k = 0; k < 64; k++) begin
            f[k]  = ($urandom_range(99) < fetch_pct);
            v[k]  = ($urandom_range(99) < wb_pct);
            wi[k] = $urandom & 32'h7FFF_FFFF;
        end
        if (halt_n > 0) begin
            nv = 0;
            for (int k = 0; k < 64; k++) begin
                if (v[k]) begin
                    nv++;
                    if (nv == halt_n) begin
                        wi[k] = HALT;
                        break;
                    end
                end
            end
        end

        // Reference: how many counted cycles the run should last without a budget limit
        natural = 1000;
        if (md == 1'b0) begin
            cnt = 0;
            for (int k = 0; k < 64; k++) begin
                if (f[k]) cnt++;
                if (cnt >= len) begin
                    natural = k + 1 + (STG - 1);
                    break;
                end
            end
        end else begin
            for (int k = 0; k < 64; k++) begin
                if (v[k] && wi[k] == HALT) begin
                    natural = k + 1;
                    break;
                end
            end
        end
        total   = (natural < MAXC) ? natural : MAXC;
        exp_to  = (natural >= MAXC);
        exp_ret = 0;
        for (int k = 0; k < total; k++) exp_ret += int'(v[k]);

        @(negedge clk);
        mode     = md;
        prog_len = 9'(len);
        start    = 1'b1;
        ld_valid = (len > 0);
        ld_data  = (len > 0) ? prog[0] : 32'h0;
        #1;
        check_val({nm, "_pre_we"}, 32'(im_we), 0);
        check_val({nm, "_pre_rdy"}, 32'(ld_ready), 0);
        @(negedge clk);
        start    = 1'b0;
        mode     = ~md;
        prog_len = '1;

        n = 0; guard = 0; stalled = 0; first = 1'b1;
        while (n < len && guard < 500) begin
            if (!first) begin
                if (stall3 && n == len / 2 && stalled < 3) begin
                    ld_valid = 1'b0;
                    stalled++;
                end else begin
                    ld_valid = ($urandom_range(99) >= stall_pct);
                end
                ld_data = ld_valid ? prog[n] : $urandom;
            end
            #1;
            if (first) check_val({nm, "_first_we"}, 32'(im_we), 1);
            check_val({nm, "_ld_ready"}, 32'(ld_ready), 1);
            check_val({nm, "_we"}, 32'(im_we), 32'(ld_valid));
            if (ld_valid) begin
                check_val({nm, "_addr"}, 32'(im_addr), n);
                check_val({nm, "_wdata"}, im_wdata, prog[n]);
                n++;
            end
            first = 1'b0;
            @(negedge clk);
            guard++;
        end
        check_val({nm, "_words_loaded"}, n, len);
        if (stall3) check_val({nm, "_stall_cycles"}, stalled, 3);

        for (int c = 0; c < 2; c++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            #1;
            check_val({nm, "_cpurst"}, 32'({cpu_rst_n, cpu_en, busy, done, ld_ready, im_we}), 32'h08);
            @(negedge clk);
        end
        ld_valid = 1'b0;

        for (int k = 0; k < total; k++) begin
            fetch_strobe = f[k];
            wb_valid     = v[k];
            wb_inst      = wi[k];
            start        = start_in_run && (k == 1);
            if (start) begin
                mode     = ~md;
                prog_len = 9'd3;
            end
            if (k == abort_k) rst_n = 1'b0;
            #1;
            check_val({nm, "_run_state"}, 32'({cpu_rst_n, cpu_en, busy, done, im_we}), 32'h1C);
            @(negedge clk);
            start = 1'b0;
            if (k == abort_k) begin
                rst_n        = 1'b1;
                fetch_strobe = 1'b0;
                wb_valid     = 1'b0;
                #1;
                check_val({nm, "_abort_ctl"},
                          32'({cpu_rst_n, cpu_en, busy, done, timeout, im_we, ld_ready}), 0);
                check_val({nm, "_abort_cyc"}, 32'(cycle_count), 0);
                check_val({nm, "_abort_ret"}, 32'(retired_count), 0);
                return;
            end
        end
        fetch_strobe = 1'b0;
        wb_valid     = 1'b0;
        #1;
        check_val({nm, "_done_state"}, 32'({cpu_rst_n, cpu_en, busy, done}), 32'h9);
        check_val({nm, "_cycles"}, 32'(cycle_count), total);
        check_val({nm, "_retired"}, 32'(retired_count), exp_ret);
        check_val({nm, "_timeout"}, 32'(timeout), 32'(exp_to));
        @(negedge clk);
        #1;
        check_val({nm, "_cycles_hold"}, 32'(cycle_count), total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        mode         = 1'b0;
        prog_len     = '0;
        ld_valid     = 1'b0;
        ld_data      = '0;
        fetch_strobe = 1'b0;
        wb_valid     = 1'b0;
        wb_inst      = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_ctl", 32'({ld_ready, im_we, cpu_rst_n, cpu_en, busy, done, timeout}), 0);
        check_val("reset_cyc", 32'(cycle_count), 0);
        check_val("reset_ret", 32'(retired_count), 0);
        check_val("reset_im", 32'({im_addr, im_wdata}), 0);
        rst_n = 1'b1;

        // name, mode, len, stall%, stall3, fetch%, wb%, halt_n, start_in_run, abort_k
        run_case("t1_fixed8",   1'b0, 8,  0,  1'b0, 100, 50, 0, 1'b0, -1);
        run_case("t2_stall",    1'b0, 10, 20, 1'b1, 70,  50, 0, 1'b0, -1);
        run_case("t3_halt6",    1'b1, 6,  0,  1'b0, 80,  60, 6, 1'b0, -1);
        run_case("t4_timeout",  1'b1, 4,  10, 1'b0, 80,  60, 0, 1'b0, -1);
        run_case("t5_abort",    1'b1, 5,  0,  1'b0, 80,  60, 0, 1'b0, 5);
        run_case("t5_fresh",    1'b0, 3,  0,  1'b0, 100, 50, 0, 1'b0, -1);
        run_case("t6_len0",     1'b0, 0,  0,  1'b0, 50,  50, 0, 1'b1, -1);
        for (int r = 0; r < 8; r++) begin
            run_case($sformatf("rnd%0d", r), 1'($urandom_range(1)), int'($urandom_range(12)),
                     int'($urandom_range(40)), 1'b0, int'($urandom_range(30, 100)),
                     int'($urandom_range(20, 80)), int'($urandom_range(8)), 1'($urandom_range(1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
